// File: rtl/alu_ctrl_exec_pkg.sv
// alu_pkg: shared encodings for the ALU control / execute stage.
//  - ALU_op encodings coming from the main control unit
//  - R-type funct codes understood by the execute stage
//  - internal operation enum and the stage FSM state enum
//  - decode_op(): maps (alu_op, funct) onto the internal operation
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_SLL,
    OP_SRL,
    OP_OR,
    OP_AND,
    OP_SLT,
    OP_MULTU,
    OP_ILL
  } op_e;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_e;

  // funct only matters for R-type; every other alu_op maps directly.
  function automatic op_e decode_op(input logic [1:0] alu_op, input logic [5:0] funct);
    op_e op;
    op = OP_ILL;
    case (alu_op)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_SUB: op = OP_SUB;
      ALUOP_OR:  op = OP_OR;
      default: begin
        case (funct)
          FUNCT_ADDU:  op = OP_ADD;
          FUNCT_SUBU:  op = OP_SUB;
          FUNCT_SLL:   op = OP_SLL;
          FUNCT_SRL:   op = OP_SRL;
          FUNCT_OR:    op = OP_OR;
          FUNCT_AND:   op = OP_AND;
          FUNCT_SLT:   op = OP_SLT;
          FUNCT_MULTU: op = OP_MULTU;
          default:     op = OP_ILL;
        endcase
      end
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_exec_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier, one partial product per clock.
// Ports:
//  clk, rst_n  clock, asynchronous active-low reset (discards any product in flight)
//  start       load a/b and begin; ignored unless the caller is idle
//  a, b        multiplicand / multiplier (DATA_W each)
//  done        high during the final step; product is valid in that same cycle
//  product     2*DATA_W-bit result, meaningful only while done is high
// A start followed by DATA_W steps means done is seen on the DATA_W-th edge after start,
// and the top level loads the product on that edge.
module alu_mul_iter #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W);

  logic                busy_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [DATA_W-1:0]   mcand_reg;
  // {hi_reg, lo_reg}: the accumulator shifts right into lo_reg while the multiplier
  // bits shift out of its bottom, so after DATA_W steps it holds the full product.
  logic [DATA_W-1:0]   hi_reg;
  logic [DATA_W-1:0]   lo_reg;

  logic [DATA_W-1:0]   addend;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   hi_next;
  logic [DATA_W-1:0]   lo_next;

  // Partial product: multiplicand gated by the current multiplier LSB.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_addend
      assign addend[gi] = mcand_reg[gi] & lo_reg[0];
    end
  endgenerate

  assign sum     = {1'b0, hi_reg} + {1'b0, addend};
  assign hi_next = sum[DATA_W:1];
  assign lo_next = {sum[0], lo_reg[DATA_W-1:1]};

  assign done    = busy_reg && (cnt_reg == '0);
  assign product = {hi_next, lo_next};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
      mcand_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else if (start && !busy_reg) begin
      busy_reg  <= 1'b1;
      cnt_reg   <= CNT_W'(DATA_W - 1);
      mcand_reg <= a;
      hi_reg    <= '0;
      lo_reg    <= b;
    end else if (busy_reg) begin
      hi_reg <= hi_next;
      lo_reg <= lo_next;
      if (cnt_reg == '0) begin
        busy_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_ctrl_exec.sv
// alu_ctrl_exec: ALU control + execute stage of the multi-cycle MIPS datapath.
// Decodes alu_op/funct, runs the operation and registers the result behind a
// valid/ready handshake on both sides. multu is handed to alu_mul_iter and takes
// DATA_W cycles; everything else completes in one.
// Ports:
//  clk, rst_n            clock, asynchronous active-low reset
//  in_valid / in_ready   request handshake (alu_op, funct, shamt, op_a, op_b)
//  out_valid / out_ready result handshake (result, result_hi, zero, illegal)
module alu_ctrl_exec
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [5:0]         funct,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  op_a,
  input  logic [DATA_W-1:0]  op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic [DATA_W-1:0]  result_hi,
  output logic               zero,
  output logic               illegal
);

  state_e              state_reg;
  logic                out_valid_reg;
  logic [DATA_W-1:0]   result_reg;
  logic [DATA_W-1:0]   result_hi_reg;
  logic                zero_reg;
  logic                illegal_reg;

  op_e                 op_sel;
  logic [DATA_W-1:0]   alu_res;
  logic                accept;
  logic                mul_start;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_product;

  assign op_sel = decode_op(alu_op, funct);

  // Including rst_n keeps in_ready low for the whole reset pulse.
  assign in_ready  = rst_n && (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op_sel == OP_MULTU);

  // Single-cycle datapath; multu and illegal produce 0 here.
  always_comb begin
    alu_res = '0;
    case (op_sel)
      OP_ADD: alu_res = op_a + op_b;
      OP_SUB: alu_res = op_a - op_b;
      OP_SLL: alu_res = op_b << shamt;
      OP_SRL: alu_res = op_b >> shamt;
      OP_OR:  alu_res = op_a | op_b;
      OP_AND: alu_res = op_a & op_b;
      OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_res = '0;
    endcase
  end

  alu_mul_iter #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      result_hi_reg <= '0;
      zero_reg      <= 1'b1;
      illegal_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (op_sel == OP_MULTU) begin
              // Previous result was consumed on this edge; nothing valid until done.
              state_reg     <= ST_MUL;
              out_valid_reg <= 1'b0;
            end else begin
              out_valid_reg <= 1'b1;
              result_reg    <= alu_res;
              result_hi_reg <= '0;
              zero_reg      <= (alu_res == '0);
              illegal_reg   <= (op_sel == OP_ILL);
            end
          end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b1;
            result_reg    <= mul_product[DATA_W-1:0];
            result_hi_reg <= mul_product[2*DATA_W-1:DATA_W];
            zero_reg      <= (mul_product == '0);
            illegal_reg   <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign result_hi = result_hi_reg;
  assign zero      = zero_reg;
  assign illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Scoreboard bench for alu_ctrl_exec: a 32-bit and an 8-bit instance. The driver pushes the
// hand-computed expected response when a request is accepted; per-instance monitors pop and
// compare whenever a result is handed over (out_valid && out_ready).
module tb_alu_ctrl_exec;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // 32-bit instance
  logic        in_valid, in_ready, out_valid, out_ready, zero, illegal;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] op_a, op_b, result, result_hi;
  // 8-bit instance
  logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8, illegal8;
  logic [1:0]  alu_op8;
  logic [5:0]  funct8;
  logic [2:0]  shamt8;
  logic [7:0]  op_a8, op_b8, result8, result_hi8;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] h;
    logic        z;
    logic        ill;
  } exp32_t;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] h;
    logic       z;
    logic       ill;
  } exp8_t;

  exp32_t q32[$];
  exp8_t  q8[$];
  exp32_t e32;
  exp8_t  e8;

  alu_ctrl_exec #(.DATA_W(32), .SHAMT_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .shamt(shamt), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_hi(result_hi), .zero(zero), .illegal(illegal)
  );

  alu_ctrl_exec #(.DATA_W(8), .SHAMT_W(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .alu_op(alu_op8), .funct(funct8), .shamt(shamt8), .op_a(op_a8), .op_b(op_b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
    .result_hi(result_hi8), .zero(zero8), .illegal(illegal8)
  );

  // Monitors: sample at the falling edge, where the handshake values are settled.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      vectors++;
      if (q32.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected32: result=%h result_hi=%h zero=%b illegal=%b with no pending request",
                 result, result_hi, zero, illegal);
      end else begin
        e32 = q32.pop_front();
        if (result !== e32.r || result_hi !== e32.h || zero !== e32.z || illegal !== e32.ill) begin
          miscompares++;
          $display("FAIL result32: got r=%h h=%h z=%b ill=%b expected r=%h h=%h z=%b ill=%b",
                   result, result_hi, zero, illegal, e32.r, e32.h, e32.z, e32.ill);
        end else begin
          $display("ok result32: r=%h h=%h z=%b ill=%b", result, result_hi, zero, illegal);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid8 && out_ready8) begin
      vectors++;
      if (q8.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected8: result=%h result_hi=%h with no pending request", result8, result_hi8);
      end else begin
        e8 = q8.pop_front();
        if (result8 !== e8.r || result_hi8 !== e8.h || zero8 !== e8.z || illegal8 !== e8.ill) begin
          miscompares++;
          $display("FAIL result8: got r=%h h=%h z=%b ill=%b expected r=%h h=%h z=%b ill=%b",
                   result8, result_hi8, zero8, illegal8, e8.r, e8.h, e8.z, e8.ill);
        end else begin
          $display("ok result8: r=%h h=%h z=%b ill=%b", result8, result_hi8, zero8, illegal8);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok %s: %h", name, act);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Drive one request (caller is at posedge+1), wait for acceptance, push expectation.
  task automatic send32(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                        input logic [31:0] a, input logic [31:0] b, input bit push,
                        input logic [31:0] er, input logic [31:0] eh, input logic ez,
                        input logic ei, output int waits);
    alu_op = op; funct = f; shamt = sh; op_a = a; op_b = b; in_valid = 1'b1;
    waits = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
    end
    if (waits >= 60) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout32: in_ready stayed 0 for 60 cycles, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) q32.push_back('{r: er, h: eh, z: ez, ill: ei});
  endtask

  task automatic send8(input logic [1:0] op, input logic [5:0] f, input logic [2:0] sh,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic [7:0] eh, input logic ez);
    int waits;
    alu_op8 = op; funct8 = f; shamt8 = sh; op_a8 = a; op_b8 = b; in_valid8 = 1'b1;
    waits = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (in_ready8) break;
      waits++;
    end
    if (waits >= 60) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout8: in_ready stayed 0 for 60 cycles, required 1");
    end
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    q8.push_back('{r: er, h: eh, z: ez, ill: 1'b0});
  endtask

  // Counts falling edges with out_valid low after a multu accept; in_ready must stay low.
  task automatic mul_latency(input string name, input int exp_cycles);
    int cyc;
    int ir_bad;
    cyc = 0;
    ir_bad = 0;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      if (!out_valid) begin
        cyc++;
        if (in_ready) ir_bad++;
      end
    end
    chk({name, "_latency"}, 64'(cyc), 64'(exp_cycles));
    chk({name, "_in_ready_low"}, 64'(ir_bad), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int cyc8;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; alu_op = '0; funct = '0; shamt = '0; op_a = '0; op_b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; alu_op8 = '0; funct8 = '0; shamt8 = '0; op_a8 = '0; op_b8 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_result_hi", 64'(result_hi), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_in_ready_low", 64'(in_ready), 64'd0);
    sync();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready_high", 64'(in_ready), 64'd1);
    chk("rst_in_ready8_high", 64'(in_ready8), 64'd1);
    sync();

    // Decode sweep
    send32(ALUOP_RTYPE, FUNCT_ADDU, 5'd0, 32'd7, 32'd5, 1, 32'd12, 32'd0, 1'b0, 1'b0, w);
    send32(ALUOP_RTYPE, FUNCT_SUBU, 5'd0, 32'd5, 32'd7, 1, 32'hFFFF_FFFE, 32'd0, 1'b0, 1'b0, w);
    send32(ALUOP_RTYPE, FUNCT_SLT, 5'd0, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 32'd0, 1'b0, 1'b0, w);
    send32(ALUOP_RTYPE, FUNCT_SLT, 5'd0, 32'd1, 32'hFFFF_FFFF, 1, 32'd0, 32'd0, 1'b1, 1'b0, w);
    send32(ALUOP_RTYPE, FUNCT_SLL, 5'd31, 32'd0, 32'd1, 1, 32'h8000_0000, 32'd0, 1'b0, 1'b0, w);
    send32(ALUOP_RTYPE, FUNCT_SLL, 5'd0, 32'd0, 32'h1234_5678, 1, 32'h1234_5678, 32'd0, 1'b0, 1'b0, w);
    send32(ALUOP_RTYPE, FUNCT_SRL, 5'd31, 32'd0, 32'h8000_0000, 1, 32'd1, 32'd0, 1'b0, 1'b0, w);
    send32(ALUOP_RTYPE, FUNCT_SRL, 5'd4, 32'd0, 32'hF000_000F, 1, 32'h0F00_0000, 32'd0, 1'b0, 1'b0, w);
    send32(ALUOP_RTYPE, FUNCT_AND, 5'd0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, 32'h0F00_0F00, 32'd0, 1'b0, 1'b0, w);
    send32(ALUOP_RTYPE, FUNCT_OR, 5'd0, 32'hA000_0005, 32'h0500_00A0, 1, 32'hA500_00A5, 32'd0, 1'b0, 1'b0, w);
    send32(ALUOP_RTYPE, 6'b111111, 5'd0, 32'd3, 32'd4, 1, 32'd0, 32'd0, 1'b1, 1'b1, w);
    send32(ALUOP_SUB, 6'b000000, 5'd0, 32'd9, 32'd9, 1, 32'd0, 32'd0, 1'b1, 1'b0, w);
    send32(ALUOP_ADD, 6'b111111, 5'd0, 32'hFFFF_FFFF, 32'd2, 1, 32'd1, 32'd0, 1'b0, 1'b0, w);
    send32(ALUOP_OR, 6'b011001, 5'd0, 32'h0000_1200, 32'h0000_0034, 1, 32'h0000_1234, 32'd0, 1'b0, 1'b0, w);

    // Multiply
    send32(ALUOP_RTYPE, FUNCT_MULTU, 5'd0, 32'hFFFF_FFFF, 32'd2, 1, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0, w);
    mul_latency("multu_big", 32);
    sync();
    send32(ALUOP_RTYPE, FUNCT_MULTU, 5'd0, 32'h1234_5678, 32'd0, 1, 32'd0, 32'd0, 1'b1, 1'b0, w);
    mul_latency("multu_zero", 32);
    sync();
    send32(ALUOP_RTYPE, FUNCT_MULTU, 5'd0, 32'h0001_0000, 32'h0003_0000, 1, 32'd0, 32'd3, 1'b0, 1'b0, w);
    mul_latency("multu_hi", 32);
    sync();

    // Backpressure: result held, in_ready low, then a new request rides the release edge.
    out_ready = 1'b0;
    send32(ALUOP_OR, 6'd0, 5'd0, 32'h0000_00F0, 32'h0000_000F, 1, 32'h0000_00FF, 32'd0, 1'b0, 1'b0, w);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_result_held", 64'(result), 64'h0000_00FF);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    sync();
    out_ready = 1'b1;
    send32(ALUOP_RTYPE, FUNCT_ADDU, 5'd0, 32'd3, 32'd4, 1, 32'd7, 32'd0, 1'b0, 1'b0, w);
    chk("bp_same_edge_accept_waits", 64'(w), 64'd0);

    // Mid-multiply reset: in-flight product is discarded.
    sync();
    send32(ALUOP_RTYPE, FUNCT_MULTU, 5'd0, 32'd3, 32'd5, 0, 32'd0, 32'd0, 1'b0, 1'b0, w);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midmul_out_valid", 64'(out_valid), 64'd0);
    chk("midmul_in_ready", 64'(in_ready), 64'd0);
    chk("midmul_result", 64'(result), 64'd0);
    chk("midmul_zero", 64'(zero), 64'd1);
    sync();
    rst_n = 1'b1;
    sync();
    send32(ALUOP_RTYPE, FUNCT_ADDU, 5'd0, 32'd1, 32'd1, 1, 32'd2, 32'd0, 1'b0, 1'b0, w);
    repeat (40) @(negedge clk);
    sync();

    // 8-bit instance
    send8(ALUOP_RTYPE, FUNCT_MULTU, 3'd0, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0);
    cyc8 = 0;
    while (!out_valid8 && cyc8 < 100) begin
      @(negedge clk);
      if (!out_valid8) cyc8++;
    end
    chk("multu8_latency", 64'(cyc8), 64'd8);
    sync();
    send8(ALUOP_RTYPE, FUNCT_SLL, 3'd7, 8'h00, 8'h01, 8'h80, 8'h00, 1'b0);
    send8(ALUOP_RTYPE, FUNCT_SRL, 3'd7, 8'h00, 8'h80, 8'h01, 8'h00, 1'b0);
    send8(ALUOP_RTYPE, FUNCT_SLT, 3'd0, 8'h80, 8'h01, 8'h01, 8'h00, 1'b0);
    send8(ALUOP_SUB, 6'd0, 3'd0, 8'h10, 8'h20, 8'hF0, 8'h00, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard32_drained", 64'(q32.size()), 64'd0);
    chk("scoreboard8_drained", 64'(q8.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
